// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    : operation encoding seen on the op port.
//   muldiv_state_t : controller states.
//   is_signed/is_div : operation decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULU = 2'd0,
        MUL  = 2'd1,
        DIVU = 2'd2,
        DIV  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_signed(input muldiv_op_t op);
        return (op == MUL) || (op == DIV);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == DIVU) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Performs BITS_PER_CYCLE shift-add steps (multiply) or restoring subtract
// steps (divide) on the 2*WIDTH accumulator.
//   is_div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i     : accumulator before the iteration
//              multiply: {partial product upper half, remaining multiplier bits}
//              divide  : {partial remainder, dividend bits / quotient bits}
//   operand_i : multiplicand magnitude or divisor magnitude
//   acc_o     : accumulator after the iteration
module muldiv_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     wide;

    // Unrolled chain of single-bit steps. The divide step shifts the next
    // dividend bit into the remainder and keeps the difference only when it
    // does not go negative; the freed low bit becomes the quotient bit. The
    // multiply step adds the multiplicand on the current multiplier LSB and
    // shifts the carry back into the top of the accumulator.
    always_comb begin
        acc  = acc_i;
        wide = '0;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            if (is_div_i) begin
                wide = acc[2*WIDTH-1:WIDTH-1];
                if (wide >= {1'b0, operand_i}) begin
                    // True difference is below the divisor, so WIDTH bits hold it.
                    acc = {wide[WIDTH-1:0] - operand_i, acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc = {wide[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                wide = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_i} : '0);
                acc  = {wide, acc[WIDTH-1:1]};
            end
        end
        acc_o = acc;
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit with ready/valid accept and
// flush. Works on operand magnitudes and fixes signs in a final FIX cycle.
// Latency from accept edge to done cycle is WIDTH/BITS_PER_CYCLE + 2 for every
// op (BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH).
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : request present;  in_ready : request accepted this cycle if valid
//   op, a, b   : operation and operands (multiplicand/dividend, multiplier/divisor)
//   flush      : abort in-flight operation, block acceptance this cycle
//   done       : one-cycle pulse, hi/lo hold a new result
//   hi, lo     : product {hi,lo}, or remainder (hi) and quotient (lo)
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    muldiv_op_t         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    muldiv_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i  (is_div(op_q)),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (step_acc)
    );

    assign in_ready = ((state_q == IDLE) || (state_q == DONE)) && !flush;
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Operand magnitudes for the datapath. The most negative value maps to
    // itself, which as an unsigned magnitude is exactly right.
    assign a_neg = is_signed(op) && a[WIDTH-1];
    assign b_neg = is_signed(op) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Sign fix-up of the magnitude result. A zero divisor yields an all-ones
    // quotient regardless of signs; the remainder naturally equals the
    // dividend because nothing was ever subtracted from it. MIN / -1 needs no
    // special case: the magnitude quotient 2^(WIDTH-1) negates to itself.
    always_comb begin
        prod = acc_q;
        if (op_q == MUL && (sign_a_q ^ sign_b_q)) begin
            prod = -acc_q;
        end
        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
        if (op_q == DIV) begin
            if (sign_a_q ^ sign_b_q) quo = -acc_q[WIDTH-1:0];
            if (sign_a_q)            rem = -acc_q[2*WIDTH-1:WIDTH];
        end
        if (b_zero_q) begin
            quo = '1;
        end
        if (is_div(op_q)) begin
            fix_hi = rem;
            fix_lo = quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // Next-state logic. CALC runs ITERS step cycles, then one extra cycle at
    // count zero so the latency is the same for every op. hi/lo are written
    // only on the FIX->DONE transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: ;
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Only reachable from IDLE or DONE, since in_ready is low elsewhere.
        if (accept) begin
            state_d   = CALC;
            cnt_d     = CNT_W'(ITERS);
            op_d      = op;
            sign_a_d  = a_neg;
            sign_b_d  = b_neg;
            b_zero_d  = (b == '0);
            if (is_div(op)) begin
                acc_d     = {{WIDTH{1'b0}}, a_mag};
                operand_d = b_mag;
            end else begin
                acc_d     = {{WIDTH{1'b0}}, b_mag};
                operand_d = a_mag;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            op_q      <= MULU;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed corner cases, randomized ops
// against an arithmetic reference model, flush, back-to-back and reset cases,
// plus a second instance retiring 4 bits per cycle.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int W    = 32;
    localparam int LAT1 = W / 1 + 2;
    localparam int LAT4 = W / 4 + 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_valid4, flush, flush4;
    muldiv_op_t     op;
    logic [W-1:0]   a, b;
    logic           in_ready, done, in_ready4, done4;
    logic [W-1:0]   hi, lo, hi4, lo4;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op), .a(a), .b(b), .flush(flush4), .done(done4), .hi(hi4), .lo(lo4)
    );

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [2*W-1:0] model(input muldiv_op_t o, input logic [W-1:0] x, y);
        longint sx, sy, q, r;
        logic [2*W-1:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MULU: res = {32'b0, x} * {32'b0, y};
            MUL:  res = sx * sy;
            DIVU: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one request to the selected instance and return at the negedge of
    // the done cycle. lat = cycles from accept edge to done cycle, -1 if never
    // accepted, 200 if done never came.
    task automatic do_op(input bit use4, input muldiv_op_t o, input logic [W-1:0] x, y,
                         output int lat);
        int guard;
        op = o; a = x; b = y;
        if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
        guard = 0;
        #1;
        while (!(use4 ? in_ready4 : in_ready) && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            in_valid = 1'b0; in_valid4 = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_valid4 = 1'b0;
        lat = 0;
        while (!(use4 ? done4 : done) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
        compared++;
        if ({hi, lo} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        compared++;
        if ({in_ready4, done4, hi4, lo4} !== {1'b1, 1'b0, 64'h0}) begin
            mismatched++; $display("[TB] FAIL reset_dut4: got %b %b %h expected 1 0 0", in_ready4, done4, {hi4, lo4});
        end
    endtask

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic test_directed();
        vec_t v [5];
        int   lat;
        v[0] = '{MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        v[4] = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, v[i].op, v[i].a, v[i].b, lat);
            compared++;
            if (lat !== LAT1) begin mismatched++; $display("[TB] FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, LAT1); end
            compared++;
            if (hi !== v[i].hi) begin mismatched++; $display("[TB] FAIL dir_hi[%0d]: got %h expected %h", i, hi, v[i].hi); end
            compared++;
            if (lo !== v[i].lo) begin mismatched++; $display("[TB] FAIL dir_lo[%0d]: got %h expected %h", i, lo, v[i].lo); end
        end
    endtask

    task automatic test_random(input bit use4, input int n);
        int             lat, sel;
        muldiv_op_t     o;
        logic [W-1:0]   x, y;
        logic [2*W-1:0] exp;
        for (int i = 0; i < n; i++) begin
            o   = muldiv_op_t'($urandom_range(0, 3));
            x   = $urandom();
            y   = $urandom();
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (sel == 2) y = W'($urandom_range(1, 20));
            if (sel == 3) x = W'($urandom_range(0, 100));
            exp = model(o, x, y);
            do_op(use4, o, x, y, lat);
            compared++;
            if (lat !== (use4 ? LAT4 : LAT1)) begin
                mismatched++; $display("[TB] FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, use4 ? LAT4 : LAT1);
            end
            compared++;
            if ((use4 ? {hi4, lo4} : {hi, lo}) !== exp) begin
                mismatched++;
                $display("[TB] FAIL rand_res[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y,
                         use4 ? {hi4, lo4} : {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_flush();
        int lat;
        bit sawDone;
        do_op(1'b0, DIVU, 32'd100, 32'd7, lat);
        compared++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin mismatched++; $display("[TB] FAIL flush_pre: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); end
        // Start MUL 5*5 in the DONE cycle, flush it 10 cycles in.
        op = MUL; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        compared++;
        if ({in_ready, done} !== 2'b10) begin mismatched++; $display("[TB] FAIL flush_ready: got ready=%b done=%b expected 1 0", in_ready, done); end
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        compared++;
        if (sawDone !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_nodone: got done pulse expected none"); end
        compared++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin mismatched++; $display("[TB] FAIL flush_keep: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); end
        // Flush in IDLE blocks acceptance.
        op = MULU; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_idle_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_idle_noaccept: got ready=%b expected 1", in_ready); end
        do_op(1'b0, DIVU, 32'd9, 32'd4, lat);
        compared++;
        if (lat !== LAT1 || {hi, lo} !== {32'd1, 32'd2}) begin
            mismatched++; $display("[TB] FAIL flush_after: got lat=%0d %h expected %0d %h", lat, {hi, lo}, LAT1, {32'd1, 32'd2});
        end
        // Flush during DONE keeps the pulse and blocks the accept.
        op = MULU; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        #1;
        compared++;
        if ({done, in_ready} !== 2'b10) begin mismatched++; $display("[TB] FAIL flush_done: got done=%b ready=%b expected 1 0", done, in_ready); end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        compared++;
        if ({done, in_ready, hi, lo} !== {1'b0, 1'b1, 32'd1, 32'd2}) begin
            mismatched++; $display("[TB] FAIL flush_done_after: got done=%b ready=%b %h", done, in_ready, {hi, lo});
        end
    endtask

    task automatic test_back_to_back();
        int lat, guard;
        op = MULU; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        guard = 0;
        #1;
        while (!in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
        @(posedge clk);
        @(negedge clk);
        op = DIVU; a = 32'd10; b = 32'd3;
        lat = 0;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        compared++;
        if (lat !== LAT1) begin mismatched++; $display("[TB] FAIL b2b_lat1: got %0d expected %0d", lat, LAT1); end
        compared++;
        if ({hi, lo, in_ready} !== {32'd0, 32'd6, 1'b1}) begin
            mismatched++; $display("[TB] FAIL b2b_res1: got %h ready=%b expected %h ready=1", {hi, lo}, in_ready, {32'd0, 32'd6});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        compared++;
        if (lat !== LAT1) begin mismatched++; $display("[TB] FAIL b2b_lat2: got %0d expected %0d", lat, LAT1); end
        compared++;
        if ({hi, lo} !== {32'd1, 32'd3}) begin mismatched++; $display("[TB] FAIL b2b_res2: got %h expected %h", {hi, lo}, {32'd1, 32'd3}); end
    endtask

    task automatic test_reset_mid();
        op = MULU; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if ({done, in_ready, hi, lo} !== {1'b0, 1'b1, 64'h0}) begin
            mismatched++; $display("[TB] FAIL reset_mid: got done=%b ready=%b %h expected 0 1 0", done, in_ready, {hi, lo});
        end
    endtask

    task automatic test_bpc4();
        int lat;
        do_op(1'b1, MULU, 32'h1234_5678, 32'h10, lat);
        compared++;
        if (lat !== LAT4) begin mismatched++; $display("[TB] FAIL bpc4_lat: got %0d expected %0d", lat, LAT4); end
        compared++;
        if ({hi4, lo4} !== {32'h1, 32'h2345_6780}) begin
            mismatched++; $display("[TB] FAIL bpc4_res: got %h expected %h", {hi4, lo4}, {32'h1, 32'h2345_6780});
        end
        test_random(1'b1, 16);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; flush = 1'b0; flush4 = 1'b0;
        op = MULU; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random(1'b0, 24);
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_bpc4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d compared", compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
